// File: rtl/trng_noise_collector.sv
// Noise-source power sequencer and LSB harvester for the TRNG: powers up the bias
// and avalanche sources, packs ADC noise LSBs into words, health-tests and buffers them.
module trng_noise_collector #(
  parameter int unsigned SETTLE_CYCLES   = 1200,
  parameter int unsigned BITS_PER_SAMPLE = 2,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REP_LIMIT       = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        noisebias_on,
  output logic [1:0]  noise_on,
  output logic        settled,
  input  logic        sample_valid,
  input  logic        sample_chan,
  input  logic [11:0] sample_data,
  output logic [31:0] rng_data,
  output logic        rng_valid,
  input  logic        rng_ready,
  output logic        health_fail,
  output logic        overflow
);

  localparam int unsigned CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned B   = BITS_PER_SAMPLE;
  localparam int unsigned SPW = 32 / BITS_PER_SAMPLE;
  localparam int unsigned SCW = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_BIAS = 2'd1,
    S_SRC  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t  state;
  state_t  state_next;
  logic [CW-1:0] dwell_cnt;
  logic          dwell_done;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OFF;
    end else begin
      state <= state_next;
    end
  end

  assign dwell_done = (dwell_cnt == CW'(SETTLE_CYCLES - 1));

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = S_OFF;
    end else begin
      case (state)
        S_OFF:   state_next = S_BIAS;
        S_BIAS:  if (dwell_done) state_next = S_SRC;
        S_SRC:   if (dwell_done) state_next = S_RUN;
        S_RUN:   state_next = S_RUN;
        default: state_next = S_OFF;
      endcase
    end
  end

  always_comb begin
    noisebias_on = 1'b0;
    noise_on     = 2'b00;
    settled      = 1'b0;
    case (state)
      S_BIAS: begin
        noisebias_on = 1'b1;
      end
      S_SRC: begin
        noisebias_on = 1'b1;
        noise_on     = 2'b11;
      end
      S_RUN: begin
        noisebias_on = 1'b1;
        noise_on     = 2'b11;
        settled      = 1'b1;
      end
      default: begin
        noisebias_on = 1'b0;
      end
    endcase
  end

  // Dwell counter restarts from zero on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if (!enable || (state != state_next)) begin
      dwell_cnt <= '0;
    end else if ((state == S_BIAS) || (state == S_SRC)) begin
      dwell_cnt <= dwell_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------- packer
  logic            sample_accept;
  logic [31:0]     pack_word;
  logic [31:0]     word_next;
  logic [SCW-1:0]  sample_cnt;
  logic            word_done;

  assign sample_accept = enable && (state == S_RUN) && sample_valid;
  assign word_next     = {pack_word[31-B:0], sample_data[B-1:0]};
  assign word_done     = sample_accept && (sample_cnt == SCW'(SPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_word  <= '0;
      sample_cnt <= '0;
    end else if (!enable) begin
      pack_word  <= '0;
      sample_cnt <= '0;
    end else if (sample_accept) begin
      pack_word  <= word_next;
      sample_cnt <= word_done ? '0 : sample_cnt + SCW'(1);
    end
  end

  // ---------------------------------------------------------------- repetition test
  logic [11:0] hist_code [2];
  logic [7:0]  run_cnt   [2];
  logic [1:0]  hist_valid;
  logic        rep_match;
  logic [7:0]  run_next;
  logic        rep_trip;

  assign rep_match = hist_valid[sample_chan] && (sample_data == hist_code[sample_chan]);

  always_comb begin
    run_next = 8'd1;
    if (rep_match) begin
      run_next = (run_cnt[sample_chan] == 8'hFF) ? 8'hFF : run_cnt[sample_chan] + 8'd1;
    end
  end

  assign rep_trip = sample_accept && (run_next == 8'(REP_LIMIT));

  // First sample on a channel after the history is cleared starts its run at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        hist_code[c] <= '0;
        run_cnt[c]   <= '0;
      end
    end else if (!enable) begin
      hist_valid <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        hist_code[c] <= '0;
        run_cnt[c]   <= '0;
      end
    end else if (sample_accept) begin
      hist_valid[sample_chan] <= 1'b1;
      hist_code[sample_chan]  <= sample_data;
      run_cnt[sample_chan]    <= run_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health_fail <= 1'b0;
    end else if (!enable) begin
      health_fail <= 1'b0;
    end else if (rep_trip) begin
      health_fail <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- output FIFO
  // Handshake: a word transfers on an edge where rng_valid and rng_ready are both
  // high; rng_valid never drops and rng_data never changes until that transfer.
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign fifo_full = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
  assign rng_valid = (fifo_cnt != '0);
  assign pop       = rng_valid && rng_ready;
  assign push_ok   = word_done && (!fifo_full || pop);
  assign drop      = word_done && fifo_full && !pop;
  assign rng_data  = rng_valid ? fifo_mem[rd_ptr] : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (!enable) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // When full with a pop, wr_ptr equals rd_ptr: the new word lands in the slot just vacated.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= word_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (!enable) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_noise_collector.sv
// Bench for trng_noise_collector: directed power/pack/overflow/health/reset scenarios
// plus a randomized phase, all compared every cycle against a timeline/queue model.
module tb_trng_noise_collector;

  localparam int S  = 16;
  localparam int B  = 2;
  localparam int D  = 4;
  localparam int RL = 31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_chan = 1'b0;
  logic [11:0] sample_data = 12'd0;
  logic        rng_ready = 1'b0;
  logic        noisebias_on;
  logic [1:0]  noise_on;
  logic        settled;
  logic [31:0] rng_data;
  logic        rng_valid;
  logic        health_fail;
  logic        overflow;

  always #5 clk = ~clk;

  trng_noise_collector #(
    .SETTLE_CYCLES(S),
    .BITS_PER_SAMPLE(B),
    .FIFO_DEPTH(D),
    .REP_LIMIT(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .noisebias_on(noisebias_on),
    .noise_on(noise_on),
    .settled(settled),
    .sample_valid(sample_valid),
    .sample_chan(sample_chan),
    .sample_data(sample_data),
    .rng_data(rng_data),
    .rng_valid(rng_valid),
    .rng_ready(rng_ready),
    .health_fail(health_fail),
    .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Power state is a pure timeline: edges seen with enable high since it last dropped.
  int          on_cycles = 0;
  bit          m_hf = 1'b0;
  bit          m_ovf = 1'b0;
  logic [31:0] exp_q[$];
  bit          bit_q[$];
  logic [11:0] m_last [2];
  int          m_run  [2];
  bit          m_seen [2];
  logic [11:0] lastc  [2];

  task automatic model_clear();
    on_cycles = 0;
    m_hf      = 1'b0;
    m_ovf     = 1'b0;
    exp_q.delete();
    bit_q.delete();
    for (int c = 0; c < 2; c++) begin
      m_last[c] = 12'd0;
      m_run[c]  = 0;
      m_seen[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit          in_run;
    bit          do_pop;
    bit          do_push;
    logic [31:0] w;
    int          c;
    if (!enable) begin
      model_clear();
    end else begin
      in_run  = (on_cycles >= 2 * S + 1);
      do_pop  = (exp_q.size() > 0) && rng_ready;
      do_push = 1'b0;
      w       = 32'd0;
      if (in_run && sample_valid) begin
        c = int'(sample_chan);
        if (m_seen[c] && (sample_data == m_last[c])) m_run[c] = (m_run[c] >= 255) ? 255 : m_run[c] + 1;
        else m_run[c] = 1;
        m_seen[c] = 1'b1;
        m_last[c] = sample_data;
        if (m_run[c] >= RL) m_hf = 1'b1;
        for (int j = B - 1; j >= 0; j--) bit_q.push_back(sample_data[j]);
        if (bit_q.size() == 32) begin
          for (int i = 0; i < 32; i++) w = {w[30:0], bit_q[i]};
          bit_q.delete();
          do_push = 1'b1;
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (exp_q.size() >= D) m_ovf = 1'b1;
        else exp_q.push_back(w);
      end
      if (on_cycles < 100000) on_cycles++;
    end
  endtask

  initial model_clear();

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_clear();
    else model_step();
  end

  // Single compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    check("noisebias_on", 32'(noisebias_on), 32'(on_cycles >= 1));
    check("noise_on", 32'(noise_on), (on_cycles >= S + 1) ? 32'd3 : 32'd0);
    check("settled", 32'(settled), 32'(on_cycles >= 2 * S + 1));
    check("rng_valid", 32'(rng_valid), 32'(exp_q.size() > 0));
    check("rng_data", rng_data, (exp_q.size() > 0) ? exp_q[0] : 32'd0);
    check("health_fail", 32'(health_fail), 32'(m_hf));
    check("overflow", 32'(overflow), 32'(m_ovf));
  end

  // ---------------------------------------------------------------- drivers
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic ch, input logic [11:0] d);
    sample_valid = 1'b1;
    sample_chan  = ch;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] l, input bit ready_on_last);
    logic [9:0] up;
    for (int i = 0; i < 32 / B; i++) begin
      up = 10'($urandom_range(0, 1023));
      if (ready_on_last && (i == 32 / B - 1)) rng_ready = 1'b1;
      send(1'(i), {up, l});
      rng_ready = 1'b0;
    end
  endtask

  task automatic power_cycle();
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(2 * S + 1);
  endtask

  task automatic drain_check(input string name, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    rng_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check(name, rng_data, w[i]);
      cyc(1);
    end
    rng_ready = 1'b0;
    check({name, "_empty"}, 32'(rng_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    lastc[0] = 12'd0;
    lastc[1] = 12'd0;
    cyc(2);
    check("reset_valid", 32'(rng_valid), 32'd0);
    check("reset_data", rng_data, 32'd0);
    check("reset_bias", 32'(noisebias_on), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Power sequence with an abort at edge 20
    enable = 1'b1;
    cyc(1);
    check("seq_bias_e0", 32'(noisebias_on), 32'd1);
    check("seq_src_e0", 32'(noise_on), 32'd0);
    cyc(15);
    check("seq_src_e15", 32'(noise_on), 32'd0);
    cyc(1);
    check("seq_src_e16", 32'(noise_on), 32'd3);
    check("seq_settled_e16", 32'(settled), 32'd0);
    cyc(3);
    enable = 1'b0;
    cyc(1);
    check("abort_bias", 32'(noisebias_on), 32'd0);
    check("abort_src", 32'(noise_on), 32'd0);
    enable = 1'b1;
    cyc(2 * S);
    check("seq_settled_e31", 32'(settled), 32'd0);
    cyc(1);
    check("seq_settled_e32", 32'(settled), 32'd1);

    // Packing: LSBs 3,2,1,0 repeating on alternating channels
    for (int i = 0; i < 16; i++) begin
      send(1'(i), {10'($urandom_range(0, 1023)), 2'(3 - (i % 4))});
      if (i == 14) check("pack_early", 32'(rng_valid), 32'd0);
    end
    check("pack_valid", 32'(rng_valid), 32'd1);
    check("pack_word", rng_data, 32'hE4E4_E4E4);
    rng_ready = 1'b1;
    cyc(1);
    rng_ready = 1'b0;
    check("pack_popped", 32'(rng_valid), 32'd0);

    // Overflow: five words into a four-deep FIFO with no consumer
    for (int w = 1; w <= 5; w++) send_word(2'(w), 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    drain_check("ovf_drain", 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0000_0000);

    // Full FIFO with simultaneous push and pop drops nothing
    power_cycle();
    check("ovf_cleared", 32'(overflow), 32'd0);
    for (int w = 1; w <= 4; w++) send_word(2'(w), 1'b0);
    send_word(2'd1, 1'b1);
    check("pushpop_no_ovf", 32'(overflow), 32'd0);
    drain_check("pushpop_drain", 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0000_0000, 32'h5555_5555);

    // Health: 30 repeats on noise0 are fine, the 31st trips
    power_cycle();
    for (int i = 0; i < 30; i++) begin
      send(1'b0, 12'h5A5);
      send(1'b1, 12'(i * 7 + 1));
    end
    check("health_30", 32'(health_fail), 32'd0);
    send(1'b0, 12'h5A5);
    check("health_31", 32'(health_fail), 32'd1);
    enable = 1'b0;
    cyc(1);
    check("health_clear", 32'(health_fail), 32'd0);

    // Gating: samples during BIAS and SRC are ignored
    enable = 1'b1;
    sample_valid = 1'b1;
    for (int i = 0; i < 2 * S; i++) begin
      sample_chan = 1'($urandom_range(0, 1));
      sample_data = 12'($urandom_range(0, 4095));
      cyc(1);
    end
    sample_valid = 1'b0;
    cyc(1);
    check("gate_settled", 32'(settled), 32'd1);
    check("gate_empty", 32'(rng_valid), 32'd0);
    send_word(2'd1, 1'b0);
    check("gate_word", rng_data, 32'h5555_5555);

    // Async reset with a half-packed word
    for (int i = 0; i < 7; i++) send(1'(i), {10'($urandom_range(0, 1023)), 2'd1});
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(rng_valid), 32'd0);
    check("areset_data", rng_data, 32'd0);
    check("areset_bias", 32'(noisebias_on), 32'd0);
    check("areset_src", 32'(noise_on), 32'd0);
    check("areset_settled", 32'(settled), 32'd0);
    #1 rst_n = 1'b1;
    cyc(2 * S + 1);
    check("areset_rerun", 32'(settled), 32'd1);
    for (int i = 0; i < 9; i++) send(1'(i), {10'($urandom_range(0, 1023)), 2'd2});
    check("areset_no_partial", 32'(rng_valid), 32'd0);
    for (int i = 0; i < 7; i++) send(1'(i), {10'($urandom_range(0, 1023)), 2'd2});
    check("areset_word", rng_data, 32'hAAAA_AAAA);

    // Randomized traffic with repeats, backpressure and occasional enable drops
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom_range(0, 599) != 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_chan  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) != 0) sample_data = lastc[sample_chan];
      else sample_data = 12'($urandom_range(0, 4095));
      lastc[sample_chan] = sample_data;
      rng_ready = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    sample_valid = 1'b0;
    rng_ready    = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trng_noise_collector.md
# trng_noise_collector

Power sequencer and bit harvester for the two avalanche noise sources of the managed TRNG. It drives `noisebias_on` and `noise_on[1:0]` through a timed power-up sequence. Once the sources have settled, it consumes digitised noise samples from the ADC sequencer (channels noise0 and noise1) and packs their LSBs into 32-bit words. It runs a repetition-count health test and presents words to the entropy consumer over a valid/ready FIFO interface.

## Interface
Parameters:
- `SETTLE_CYCLES`, 1200: dwell in each power-up phase (100 us at 12 MHz); minimum 1.
- `BITS_PER_SAMPLE`, 2: LSBs harvested per sample; must divide 32 (1, 2, 4 or 8).
- `FIFO_DEPTH`, 4: output word FIFO depth; power of two, ≥2.
- `REP_LIMIT`, 31: consecutive identical samples on one channel that trip the health test; 2..255.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level request for noise generation.
- `noisebias_on` out 1: noise bias supply enable.
- `noise_on` out 2: per-source enables, [0]=noise0, [1]=noise1.
- `settled` out 1: high while the FSM is in RUN.
- `sample_valid` in 1: one-cycle strobe, ADC sample present.
- `sample_chan` in 1: 0=noise0, 1=noise1.
- `sample_data` in 12: ADC code.
- `rng_data` out 32: FIFO head word.
- `rng_valid` out 1: FIFO not empty.
- `rng_ready` in 1: consumer accepts the head word.
- `health_fail` out 1: sticky repetition-test failure.
- `overflow` out 1: sticky flag, a completed word was dropped because the FIFO was full.

## Operation
- States: OFF, BIAS, SRC, RUN.
- OFF: all enables 0. When `enable`=1, go to BIAS.
- BIAS: `noisebias_on`=1. Dwell counter loads 0 on entry. After the counter reaches SETTLE_CYCLES-1, go to SRC.
- SRC: `noisebias_on`=1, `noise_on`=2'b11. Same dwell, then go to RUN.
- RUN: enables held as in SRC; `settled`=1.
- `enable`=0 in any state: go to OFF on the next edge. This also:
  - clears the dwell counter, packer, sample count and per-channel history;
  - flushes the FIFO;
  - clears `health_fail` and `overflow`.
- Samples are accepted only in RUN with `sample_valid`=1. They are ignored in all other states.
- Packer, per accepted sample: `word <= {word[31-B:0], sample_data[B-1:0]}`, where B = BITS_PER_SAMPLE. Samples from both channels are packed in arrival order.
  - After 32/B samples, the composed word (including the current sample) is pushed into the FIFO on the same edge, and the sample count wraps to 0.
- Health test, per channel: keep the previous 12-bit code and a run counter (8 bits, saturating).
  - Sample equal to the previous code on its channel: counter increments.
  - Otherwise: counter resets to 1.
  - Counter reaching REP_LIMIT sets `health_fail`.
  - The first sample after entering RUN starts the counter at 1.
- `health_fail` does not stop harvesting or power. The consumer decides what to do.
- FIFO:
  - Push when full and no pop: word dropped, `overflow` set, FIFO contents unchanged.
  - Push and pop on the same edge when full: both occur, nothing dropped.
  - Pop when empty: ignored.

## Timing
- Reset values: `noisebias_on`=0, `noise_on`=0, `settled`=0, `rng_valid`=0, `rng_data`=0, `health_fail`=0, `overflow`=0. State is OFF.
- `enable` rises before edge 0:
  - `noisebias_on` high after edge 0;
  - `noise_on` high after edge SETTLE_CYCLES;
  - `settled` high after edge 2·SETTLE_CYCLES.
- `enable` falls before edge k: all outputs return to reset values after edge k.
- Word latency: the sample completing a word is accepted at edge k, and `rng_valid` is high after edge k. There is no same-cycle bypass from input to output.
- Pop: `rng_valid`&`rng_ready` at edge k advances the head. `rng_data` and `rng_valid` reflect the new head after edge k.
- `rng_data` is stable while `rng_valid`=1 and `rng_ready`=0.
- Throughput: one sample per cycle, one pop per cycle.

## Test plan
- Power sequence, SETTLE_CYCLES=16: raise `enable`. Expect:
  - `noisebias_on` 1 after edge 0;
  - `noise_on`=2'b11 after edge 16;
  - `settled` after edge 32.
  - Drop `enable` at edge 20: all outputs 0 after edge 20, and the sequence restarts cleanly on re-enable.
- Packing, B=2: in RUN, feed 16 samples with `sample_data` LSBs 3,2,1,0 repeating, alternating channels. Expect exactly one word, `rng_data`=32'hE4E4E4E4, with `rng_valid` high the cycle after the 16th sample.
- Backpressure/overflow, FIFO_DEPTH=4, `rng_ready`=0: push 5 words. Expect:
  - `overflow`=1;
  - the 4 stored words pop in order once `rng_ready`=1;
  - then `rng_valid`=0.
  - Repeat with full FIFO plus simultaneous push/pop: `overflow` stays 0.
- Health test, REP_LIMIT=31: send 30 identical codes 12'h5A5 on noise0, interleaved with varying noise1 codes, and expect `health_fail`=0. Send the 31st and expect `health_fail`=1. Drop `enable` and expect `health_fail`=0.
- Gating: samples during BIAS/SRC produce no words. Async `rst_n` pulse mid-RUN with a half-packed word: outputs at reset values immediately, FIFO empty, and no partial word emitted after recovery.
